// File: rtl/valu_seq.sv
// Sequential vector ALU: accepts one request, processes one lane per cycle,
// then holds the registered result until the consumer takes it.
module valu_seq #(
    parameter int unsigned LANES = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned FRAC  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alucontrol,
    input  logic [LANES*W-1:0] vec_a,
    input  logic [LANES*W-1:0] vec_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] result,
    output logic               out_err
);

    localparam int unsigned VW = LANES * W;
    localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_VSUM = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_VSET = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [VW-1:0]       a_q, a_d, b_q, b_d, res_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        acc_q, acc_d;
    logic                err_d;
    logic                legal_c, last_c;
    logic [W-1:0]        lane_a, lane_b;
    logic signed [2*W-1:0] prod;

    assign legal_c = (op_q == OP_MUL) || (op_q == OP_ADD) || (op_q == OP_VSUM) ||
                     (op_q == OP_SUB) || (op_q == OP_VSET);
    assign last_c  = (cnt_q == CW'(LANES - 1));

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    // Next-state logic; an illegal code spends a single cycle in EXEC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    if (!legal_c || last_c) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane datapath and register next values.
    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        res_d  = result;
        err_d  = out_err;
        lane_a = a_q[int'(cnt_q)*W +: W];
        lane_b = b_q[int'(cnt_q)*W +: W];
        prod   = $signed({{W{lane_a[W-1]}}, lane_a}) * $signed({{W{lane_b[W-1]}}, lane_b});
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = alucontrol;
                    a_d   = vec_a;
                    b_d   = vec_b;
                    cnt_d = '0;
                    acc_d = '0;
                    res_d = '0;
                    err_d = 1'b0;
                end
            end
            EXEC: begin
                if (!legal_c) begin
                    res_d = '0;
                    err_d = 1'b1;
                end else begin
                    case (op_q)
                        OP_ADD:  res_d[int'(cnt_q)*W +: W] = lane_a + lane_b;
                        OP_SUB:  res_d[int'(cnt_q)*W +: W] = lane_a - lane_b;
                        OP_MUL:  res_d[int'(cnt_q)*W +: W] = W'(prod >>> FRAC);
                        OP_VSET: res_d[int'(cnt_q)*W +: W] = b_q[W-1:0];
                        OP_VSUM: begin
                            acc_d        = acc_q + lane_a;
                            res_d[W-1:0] = acc_d;
                        end
                        default: ;
                    endcase
                    cnt_d = last_c ? '0 : cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            result  <= '0;
            out_err <= 1'b0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            result  <= res_d;
            out_err <= err_d;
        end
    end

endmodule

// File: tb/tb_valu_seq.sv
// Directed self-checking bench for valu_seq with default parameters.
module tb_valu_seq;

    localparam int unsigned LANES = 4;
    localparam int unsigned W     = 16;
    localparam int unsigned VW    = LANES * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    alucontrol;
    logic [VW-1:0] vec_a, vec_b;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] result;
    logic          out_err;

    int total = 0;
    int bad   = 0;

    valu_seq #(.LANES(LANES), .W(W), .FRAC(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alucontrol(alucontrol), .vec_a(vec_a), .vec_b(vec_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Issue one request, scramble inputs after accept, wait for the result, consume it.
    task automatic run_op(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          output logic [VW-1:0] res, output logic err, output int lat,
                          output logic rdy_after);
        @(negedge clk);
        alucontrol = op; vec_a = a; vec_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; alucontrol = 3'b111;
        vec_a = {$urandom, $urandom}; vec_b = {$urandom, $urandom};
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        res = result;
        err = out_err;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        rdy_after = in_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alucontrol = 3'b0; vec_a = '0; vec_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result got %h want 0", result); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got %b want 0", out_err); end
    endtask

    task automatic test_add();
        logic [VW-1:0] r; logic e, rd; int lat;
        run_op(3'b010, {16'hFFFF, 16'h7FFF, 16'h0200, 16'h0100},
               {16'h0001, 16'h0001, 16'h0100, 16'h0100}, r, e, lat, rd);
        total++; if (r !== {16'h0000, 16'h8000, 16'h0300, 16'h0200}) begin bad++; $display("FAIL add_result got %h want 0000800003000200", r); end
        total++; if (lat !== 4) begin bad++; $display("FAIL add_latency got %0d want 4", lat); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL add_err got %b want 0", e); end
        total++; if (rd !== 1'b1) begin bad++; $display("FAIL add_ready_after got %b want 1", rd); end
    endtask

    task automatic test_sub();
        logic [VW-1:0] r; logic e, rd; int lat;
        run_op(3'b110, {16'h0000, 16'h8000, 16'h0005, 16'h0010},
               {16'h0001, 16'h0001, 16'h0007, 16'h0003}, r, e, lat, rd);
        total++; if (r !== {16'hFFFF, 16'h7FFF, 16'hFFFE, 16'h000D}) begin bad++; $display("FAIL sub_result got %h want FFFF7FFFFFFE000D", r); end
    endtask

    task automatic test_mulfp();
        logic [VW-1:0] r; logic e, rd; int lat;
        run_op(3'b000, {4{16'h0180}}, {16'hFE00, 16'h0200, 16'h0080, 16'h0100}, r, e, lat, rd);
        total++; if (r !== {16'hFD00, 16'h0300, 16'h00C0, 16'h0180}) begin bad++; $display("FAIL mulfp_result got %h want FD00030000C00180", r); end
        total++; if (lat !== 4) begin bad++; $display("FAIL mulfp_latency got %0d want 4", lat); end
    endtask

    task automatic test_vsum_vset();
        logic [VW-1:0] r; logic e, rd; int lat;
        run_op(3'b011, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, {4{16'h5555}}, r, e, lat, rd);
        total++; if (r !== {16'h0000, 16'h0000, 16'h0000, 16'h000A}) begin bad++; $display("FAIL vsum_result got %h want 000000000000000A", r); end
        run_op(3'b111, {4{16'h9999}}, {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h1234}, r, e, lat, rd);
        total++; if (r !== {4{16'h1234}}) begin bad++; $display("FAIL vset_result got %h want 1234123412341234", r); end
    endtask

    task automatic test_illegal();
        logic [VW-1:0] r; logic e, rd; int lat;
        run_op(3'b101, {4{16'h1111}}, {4{16'h2222}}, r, e, lat, rd);
        total++; if (lat !== 1) begin bad++; $display("FAIL illegal_latency got %0d want 1", lat); end
        total++; if (r !== '0) begin bad++; $display("FAIL illegal_result got %h want 0", r); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL illegal_err got %b want 1", e); end
        run_op(3'b010, {4{16'h0001}}, {4{16'h0002}}, r, e, lat, rd);
        total++; if (r !== {4{16'h0003}} || e !== 1'b0) begin bad++; $display("FAIL after_illegal got %h err %b want 0003000300030003 err 0", r, e); end
    endtask

    task automatic test_hold();
        int lat = 0;
        @(negedge clk);
        alucontrol = 3'b010; vec_a = {4{16'h0010}}; vec_b = {4{16'h0001}}; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k % 2 == 0); alucontrol = 3'b110;
            vec_a = {$urandom, $urandom}; vec_b = {$urandom, $urandom};
            @(posedge clk);
            #1;
            total++;
            if (result !== {4{16'h0011}} || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d got res %h valid %b ready %b want 0011001100110011 1 0", k, result, out_valid, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_release got valid %b ready %b want 0 1", out_valid, in_ready); end
        @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL no_accept_on_consume got ready %b want 1", in_ready); end
    endtask

    task automatic test_reset_abort();
        logic [VW-1:0] r; logic e, rd; int lat; int seen = 0;
        @(negedge clk);
        alucontrol = 3'b010; vec_a = {4{16'h0100}}; vec_b = {4{16'h0100}}; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || result !== '0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL abort_state got valid %b res %h err %b ready %b want 0 0 0 1", out_valid, result, out_err, in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
        run_op(3'b010, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, {4{16'h0010}}, r, e, lat, rd);
        total++; if (r !== {16'h0014, 16'h0013, 16'h0012, 16'h0011}) begin bad++; $display("FAIL abort_next got %h want 0014001300120011", r); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mulfp();
        test_vsum_vset();
        test_illegal();
        test_hold();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
